// File: rtl/wmem_pkg.sv
// Shared definitions for the weight memory bank slice.
//   wmem_state_e : streaming controller states (IDLE, RUN, DRAIN)
//   sel_w()      : width of the bank-select field for a given neuron count
package wmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } wmem_state_e;

    function automatic int unsigned sel_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/weight_mem_bank_if.sv
// Load/stream bus of weight_mem_bank.
//   load port  : wen, wsel, waddr, wdata
//   stream ctl : start, stall (in), busy (out)
//   stream data: wout, wvalid, wlast (out)
// master = driver of the load/stream controls, slave = the memory bank.
interface weight_mem_bank_if
    import wmem_pkg::*;
#(
    parameter int unsigned NUM_NEURONS = 4,
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned DATA_WIDTH  = 16
);
    localparam int unsigned SEL_W = sel_w(NUM_NEURONS);

    logic                              wen;
    logic [SEL_W-1:0]                  wsel;
    logic [ADDR_WIDTH-1:0]             waddr;
    logic [DATA_WIDTH-1:0]             wdata;
    logic                              start;
    logic                              stall;
    logic                              busy;
    logic [NUM_NEURONS*DATA_WIDTH-1:0] wout;
    logic                              wvalid;
    logic                              wlast;

    modport master (
        output wen, wsel, waddr, wdata, start, stall,
        input  busy, wout, wvalid, wlast
    );

    modport slave (
        input  wen, wsel, waddr, wdata, start, stall,
        output busy, wout, wvalid, wlast
    );

endinterface

// File: rtl/wmem_bank.sv
// One weight bank: 2**ADDR_WIDTH x DATA_WIDTH block RAM, one write port and
// one registered read port, read-first on a same-address collision.
//   clk, rst_n   : clock, async active-low reset (read register only)
//   we/waddr/wdata : write port
//   re/raddr     : read enable and address; rdata updates only when re=1
//   rdata        : registered read data
module wmem_bank #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Storage has no reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Non-blocking read of mem yields the pre-write word on a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/weight_mem_bank.sv
// NUM_NEURONS parallel weight banks streamed out as one vector per cycle.
//   clk, rst_n : clock, async active-low reset
//   bus        : weight_mem_bank_if.slave (load port, start/stall/busy,
//                wout/wvalid/wlast stream)
// A start pulse reads addresses 0..NUM_WEIGHTS-1 from all banks in parallel;
// stall freezes the whole read pipeline. Writes are accepted in any state.
// Build option: define WMEM_OUT_REG_EN to add an output register stage
// (read latency 2 instead of 1).
module weight_mem_bank
    import wmem_pkg::*;
#(
    parameter int unsigned NUM_NEURONS = 4,
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned NUM_WEIGHTS = 784
) (
    input  logic             clk,
    input  logic             rst_n,
    weight_mem_bank_if.slave bus
);
    localparam int unsigned           SEL_W     = sel_w(NUM_NEURONS);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WEIGHTS - 1);

    wmem_state_e                       state, state_nxt;
    logic [ADDR_WIDTH-1:0]             raddr;
    logic                              rd_issue;
    logic                              rd_last;
    logic                              v1, l1;
    logic                              out_last;
    logic [DATA_WIDTH-1:0]             rd [NUM_NEURONS];
    logic [NUM_NEURONS*DATA_WIDTH-1:0] rd_flat;

    assign rd_last  = rd_issue && (raddr == LAST_ADDR);
    assign bus.busy = (state != IDLE);

    always_comb begin
        state_nxt = state;
        rd_issue  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = RUN;
            end
            RUN: begin
                if (!bus.stall) begin
                    rd_issue = 1'b1;
                    if (raddr == LAST_ADDR) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Leave only once the final vector has been taken.
                if (out_last && !bus.stall) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            raddr <= '0;
        end else begin
            state <= state_nxt;
            if (rd_issue) begin
                raddr <= rd_last ? '0 : raddr + 1'b1;
            end
        end
    end

    // Valid/last track the bank read register and freeze with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            l1 <= 1'b0;
        end else if (!bus.stall) begin
            v1 <= rd_issue;
            l1 <= rd_last;
        end
    end

    for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_bank
        wmem_bank #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_bank (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (bus.wen && (bus.wsel == SEL_W'(n))),
            .waddr (bus.waddr),
            .wdata (bus.wdata),
            .re    (rd_issue),
            .raddr (raddr),
            .rdata (rd[n])
        );
    end

    always_comb begin
        rd_flat = '0;
        for (int unsigned n = 0; n < NUM_NEURONS; n++) begin
            rd_flat[n*DATA_WIDTH +: DATA_WIDTH] = rd[n];
        end
    end

`ifdef WMEM_OUT_REG_EN
    logic [NUM_NEURONS*DATA_WIDTH-1:0] wout_q;
    logic                              v2, l2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wout_q <= '0;
            v2     <= 1'b0;
            l2     <= 1'b0;
        end else if (!bus.stall) begin
            v2 <= v1;
            l2 <= l1;
            if (v1) wout_q <= rd_flat;
        end
    end

    assign bus.wout   = wout_q;
    assign bus.wvalid = v2;
    assign bus.wlast  = l2;
    assign out_last   = l2;
`else
    assign bus.wout   = rd_flat;
    assign bus.wvalid = v1;
    assign bus.wlast  = l1;
    assign out_last   = l1;
`endif

endmodule

// File: tb/tb_weight_mem_bank.sv
// Self-checking bench for weight_mem_bank (main instance: 4 banks, 8 weights;
// second instance: 3 banks, 1 weight, for out-of-range select and the
// single-word run). Honours WMEM_OUT_REG_EN for the expected latency.
module tb_weight_mem_bank;

    localparam int NN = 4;
    localparam int AW = 4;
    localparam int DW = 16;
    localparam int NW = 8;
`ifdef WMEM_OUT_REG_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    weight_mem_bank_if #(.NUM_NEURONS(NN), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    weight_mem_bank #(.NUM_NEURONS(NN), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WEIGHTS(NW))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    weight_mem_bank_if #(.NUM_NEURONS(3), .ADDR_WIDTH(2), .DATA_WIDTH(DW)) bus3 ();
    weight_mem_bank #(.NUM_NEURONS(3), .ADDR_WIDTH(2), .DATA_WIDTH(DW), .NUM_WEIGHTS(1))
        dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    // Reference contents of the main instance's banks.
    logic [DW-1:0] mdl [NN][2**AW];

    int nvec = 0;
    int nmis = 0;

    typedef struct {
        logic start;
        logic stall;
        logic busy;
        logic valid;
        logic last;
        int   idx;    // vector index expected on wout, -1 = don't care
    } rec_t;
    rec_t tbl[$];

    function automatic logic [63:0] vec(input int k);
        logic [63:0] v;
        for (int n = 0; n < NN; n++) v[n*DW +: DW] = mdl[n][k];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wr(input int sel, input int addr, input logic [DW-1:0] d);
        bus.wen   = 1'b1;
        bus.wsel  = 2'(sel);
        bus.waddr = 4'(addr);
        bus.wdata = d;
        @(negedge clk);
        bus.wen = 1'b0;
        mdl[sel][addr] = d;
    endtask

    // Cycle 0 is the start cycle; vector k nominally appears at cycle 1+L+k.
    // With st=1: stall during cycles 4+L..6+L (vector 3 shown for 4 cycles)
    // and a second start pulse while busy.
    task automatic build(input bit st);
        int   lastpos, nc, p;
        rec_t r;
        lastpos = 1 + L + 7 + (st ? 3 : 0);
        nc = lastpos + 3;
        tbl.delete();
        for (int c = 0; c < nc; c++) begin
            r.start = (c == 0) || (st && c == 3);
            r.stall = st && (c >= 4 + L) && (c <= 6 + L);
            r.busy  = (c >= 1) && (c <= lastpos);
            r.valid = 1'b0;
            r.last  = 1'b0;
            r.idx   = (c > lastpos) ? 7 : -1;
            tbl.push_back(r);
        end
        for (int k = 0; k < NW; k++) begin
            p = 1 + L + k + ((st && k >= 4) ? 3 : 0);
            tbl[p].valid = 1'b1;
            tbl[p].last  = (k == NW - 1);
            tbl[p].idx   = k;
        end
        if (st) begin
            for (int h = 1; h <= 3; h++) begin
                tbl[4 + L + h].valid = 1'b1;
                tbl[4 + L + h].idx   = 3;
            end
        end
    endtask

    task automatic apply_tbl(input string nm);
        for (int c = 0; c < tbl.size(); c++) begin
            chk($sformatf("%s c%0d busy/valid/last", nm, c),
                {bus.busy, bus.wvalid, bus.wlast}, {tbl[c].busy, tbl[c].valid, tbl[c].last});
            if (tbl[c].idx >= 0)
                chk($sformatf("%s c%0d wout", nm, c), bus.wout, vec(tbl[c].idx));
            bus.start = tbl[c].start;
            bus.stall = tbl[c].stall;
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.stall = 1'b0;
    endtask

    // One run with random stalls, scored against a snapshot of the model.
    // caddr >= 0 writes cdata to bank 1 at caddr in the cycle that address
    // is read (requires stall_pct = 0); the run must still see the old word.
    task automatic run_chk(input int stall_pct, input int caddr, input logic [DW-1:0] cdata);
        logic [63:0] ex [NW];
        int got, c, li;
        bit pst, lv;
        for (int k = 0; k < NW; k++) ex[k] = vec(k);
        got = 0; c = 0; li = 0; pst = 1'b0; lv = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        c = 1;
        while (!(got == NW && !bus.busy) && c < 300) begin
            if (pst) begin
                if (lv) chk("held vector", {bus.wvalid, bus.wlast, bus.wout}, {1'b1, li == NW - 1, ex[li]});
                else    chk("held idle", bus.wvalid, 1'b0);
            end else if (bus.wvalid) begin
                if (got < NW) chk($sformatf("vector %0d", got), {bus.wlast, bus.wout}, {got == NW - 1, ex[got]});
                else          chk("vector count", 80'(got + 1), 80'(NW));
                li = got; lv = 1'b1; got++;
            end else begin
                lv = 1'b0;
                chk("idle wlast", bus.wlast, 1'b0);
            end
            bus.stall = ($urandom_range(99) < stall_pct);
            pst = bus.stall;
            if (caddr >= 0 && c == 1 + caddr) begin
                bus.wen = 1'b1; bus.wsel = 2'd1; bus.waddr = 4'(caddr); bus.wdata = cdata;
            end else begin
                bus.wen = 1'b0;
            end
            @(negedge clk);
            c++;
        end
        bus.stall = 1'b0;
        bus.wen = 1'b0;
        chk("vectors delivered", 80'(got), 80'(NW));
        chk("run timeout", 80'(c >= 300), 80'(0));
        if (caddr >= 0) mdl[1][caddr] = cdata;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv, vc;
        logic [1:0]    s3 [4];
        logic [DW-1:0] d3 [4];

        bus.wen = 0; bus.wsel = 0; bus.waddr = 0; bus.wdata = 0; bus.start = 0; bus.stall = 0;
        bus3.wen = 0; bus3.wsel = 0; bus3.waddr = 0; bus3.wdata = 0; bus3.start = 0; bus3.stall = 0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("reset outputs", {bus.busy, bus.wvalid, bus.wlast, bus.wout}, 80'(0));
        chk("reset outputs dut3", {bus3.busy, bus3.wvalid, bus3.wlast, bus3.wout}, 80'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Load bank n addr k = n*16+k.
        for (int n = 0; n < NN; n++)
            for (int k = 0; k < NW; k++)
                wr(n, k, DW'(n * 16 + k));

        build(1'b0); apply_tbl("stream");
        build(1'b1); apply_tbl("stall");

        // Read-first collision, then the new word on the next run.
        run_chk(0, 3, 16'hBEEF);
        run_chk(0, -1, '0);

        // Random writes and stalls.
        for (int r = 0; r < 5; r++) begin
            for (int w = 0; w < 6; w++)
                wr($urandom_range(NN - 1), $urandom_range(NW - 1), DW'($urandom));
            run_chk(30, -1, '0);
        end

        // Three-bank instance: out-of-range select ignored, single-word run.
        s3 = '{2'd0, 2'd1, 2'd2, 2'd3};
        d3 = '{16'h1111, 16'h2222, 16'h3333, 16'hDEAD};
        for (int i = 0; i < 4; i++) begin
            bus3.wen = 1'b1; bus3.wsel = s3[i]; bus3.waddr = '0; bus3.wdata = d3[i];
            @(negedge clk);
        end
        bus3.wen = 1'b0;
        bus3.start = 1'b1;
        @(negedge clk);
        bus3.start = 1'b0;
        nv = 0; vc = -1;
        for (int c = 1; c < 8; c++) begin
            if (bus3.wvalid) begin
                nv++; vc = c;
                chk("single word vector", {bus3.wlast, bus3.wout}, {1'b1, 48'h3333_2222_1111});
            end
            @(negedge clk);
        end
        chk("single word count", 80'(nv), 80'(1));
        chk("single word cycle", 80'(vc), 80'(1 + L));
        chk("single word busy end", bus3.busy, 1'b0);

        // Reset in the middle of a run.
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4 + L) @(negedge clk);
        chk("pre-reset vector 4", {bus.wvalid, bus.wout}, {1'b1, vec(4)});
        #1 rst_n = 1'b0;
        #1 chk("async reset outputs", {bus.busy, bus.wvalid, bus.wlast, bus.wout}, 80'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk($sformatf("post-reset quiet %0d", c), {bus.busy, bus.wvalid}, 80'(0));
        end
        run_chk(30, -1, '0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
